cmd_broadcaster: RTL and testbench

CMD_BROADCASTER -- requirements
Module: cmd_broadcaster

---
 rtl/cmd_broadcaster.sv | 105 ++++++++++
 tb/tb_cmd_broadcaster.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cmd_broadcaster.sv
// Broadcasts each buffered upstream command to every light bank; the head pops once all banks
// have taken it. After the last-flagged command drains, raises the cascade seed.
module cmd_broadcaster #(
  parameter int CMD_DATA_WIDTH  = 50,
  parameter int NUM_BANKS       = 4,
  parameter int INTENSITY_WIDTH = 24,
  parameter int FIFO_DEPTH      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CMD_DATA_WIDTH-1:0]  in_data,
  input  logic                       in_last,
  output logic [NUM_BANKS-1:0]       bank_valid,
  input  logic [NUM_BANKS-1:0]       bank_ready,
  output logic [CMD_DATA_WIDTH-1:0]  bank_data,
  output logic                       bank_last,
  output logic                       seed_valid,
  output logic [INTENSITY_WIDTH-1:0] seed_intensity,
  output logic [31:0]                cmd_count
);

  // state | meaning
  // RUN   | accepting upstream commands and broadcasting
  // FLUSH | last command accepted, draining the buffer
  // DONE  | last command broadcast, seed held valid until reset
  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [NUM_BANKS-1:0] ALL_BANKS = '1;

  state_t                    state, state_n;
  logic [CMD_DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]     mem_last;
  logic [PTR_W-1:0]          rd_ptr, wr_ptr;
  logic [CNT_W-1:0]          count, count_n;
  logic [NUM_BANKS-1:0]      accepted, accepted_n, handshake;
  logic                      push, pop, not_empty, in_ready_n;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign not_empty      = (count != '0);
  assign bank_valid     = {NUM_BANKS{not_empty && (state != DONE)}} & ~accepted;
  assign handshake      = bank_valid & bank_ready;
  assign pop            = not_empty && ((accepted | handshake) == ALL_BANKS);
  assign push           = in_valid && in_ready;
  assign bank_data      = not_empty ? mem_data[rd_ptr] : '0;
  assign bank_last      = not_empty ? mem_last[rd_ptr] : 1'b0;
  assign seed_valid     = (state == DONE);
  assign seed_intensity = '0;

  always_comb begin
    state_n    = state;
    count_n    = count;
    accepted_n = pop ? '0 : (accepted | handshake);
    case ({push, pop})
      2'b10:   count_n = count + CNT_W'(1);
      2'b01:   count_n = count - CNT_W'(1);
      default: count_n = count;
    endcase
    case (state)
      RUN:     if (push && in_last) state_n = FLUSH;
      FLUSH:   if (pop && bank_last) state_n = DONE;
      DONE:    state_n = DONE;
      default: state_n = RUN;
    endcase
    // Registered ready: space freed by a pop only shows up the following cycle.
    in_ready_n = (state_n == RUN) && (count_n < CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      accepted  <= '0;
      in_ready  <= 1'b0;
      cmd_count <= '0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      accepted <= accepted_n;
      in_ready <= in_ready_n;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr    <= ptr_inc(rd_ptr);
        cmd_count <= cmd_count + 32'd1;
      end
    end
  end

  // Storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_last[wr_ptr] <= in_last;
    end
  end

endmodule

// File: tb/tb_cmd_broadcaster.sv
// Directed self-checking bench for cmd_broadcaster with default parameters (4 banks, depth 2).
module tb_cmd_broadcaster;
  localparam int W  = 50;
  localparam int NB = 4;
  localparam int IW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic [NB-1:0] bank_valid;
  logic [NB-1:0] bank_ready;
  logic [W-1:0]  bank_data;
  logic          bank_last;
  logic          seed_valid;
  logic [IW-1:0] seed_intensity;
  logic [31:0]   cmd_count;

  int n_checks = 0;
  int n_fail   = 0;

  cmd_broadcaster dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .bank_valid(bank_valid), .bank_ready(bank_ready), .bank_data(bank_data),
    .bank_last(bank_last), .seed_valid(seed_valid), .seed_intensity(seed_intensity),
    .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid = 0; in_data = '0; in_last = 0; bank_ready = '0;
    reset = 1;
    step; step;
    reset = 0;
    step;
  endtask

  task automatic test_reset;
    in_valid = 0; in_data = '0; in_last = 0; bank_ready = '1;
    reset = 1;
    step; step;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    n_checks++; if (bank_valid !== 4'h0) begin n_fail++; $display("FAIL rst_bank_valid got %h exp 0", bank_valid); end
    n_checks++; if (bank_data !== '0 || bank_last !== 1'b0) begin n_fail++; $display("FAIL rst_bank_data got %h/%b exp 0/0", bank_data, bank_last); end
    n_checks++; if (seed_valid !== 1'b0 || seed_intensity !== '0) begin n_fail++; $display("FAIL rst_seed got %b/%h exp 0/0", seed_valid, seed_intensity); end
    n_checks++; if (cmd_count !== 32'd0) begin n_fail++; $display("FAIL rst_cmd_count got %0d exp 0", cmd_count); end
    reset = 0;
    step;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_rise got %b exp 1", in_ready); end
  endtask

  task automatic test_back_to_back;
    int sent, pops, first_pop, last_pop, seed_cyc;
    do_reset;
    bank_ready = '1;
    sent = 0; pops = 0; first_pop = -1; last_pop = -1; seed_cyc = -1;
    for (int cyc = 0; cyc < 30 && seed_cyc < 0; cyc++) begin
      in_valid = (sent < 5);
      in_data  = W'(sent + 1);
      in_last  = (sent == 4);
      if (seed_valid === 1'b1) seed_cyc = cyc;
      if (bank_valid === 4'hF) begin
        n_checks++; if (bank_data !== W'(pops + 1)) begin n_fail++; $display("FAIL b2b_data got %h exp %h", bank_data, W'(pops + 1)); end
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (in_valid && in_ready) sent++;
      step;
    end
    in_valid = 0;
    n_checks++; if (pops != 5) begin n_fail++; $display("FAIL b2b_pops got %0d exp 5", pops); end
    n_checks++; if (last_pop - first_pop != 4) begin n_fail++; $display("FAIL b2b_consecutive got span %0d exp 4", last_pop - first_pop); end
    n_checks++; if (seed_cyc != last_pop + 1) begin n_fail++; $display("FAIL b2b_seed_cycle got %0d exp %0d", seed_cyc, last_pop + 1); end
    n_checks++; if (cmd_count !== 32'd5) begin n_fail++; $display("FAIL b2b_cmd_count got %0d exp 5", cmd_count); end
  endtask

  task automatic test_partial_accept;
    do_reset;
    in_valid = 1; in_data = 50'h0ABC_1234_5678; in_last = 0;
    step;
    in_valid = 0;
    n_checks++; if (bank_valid !== 4'hF) begin n_fail++; $display("FAIL part_initial_valid got %h exp f", bank_valid); end
    bank_ready = 4'b0101;
    step;
    n_checks++; if (bank_valid !== 4'b1010) begin n_fail++; $display("FAIL part_after_0101 got %b exp 1010", bank_valid); end
    n_checks++; if (cmd_count !== 32'd0) begin n_fail++; $display("FAIL part_no_pop got %0d exp 0", cmd_count); end
    step; step;
    n_checks++; if (bank_valid !== 4'b1010) begin n_fail++; $display("FAIL part_hold got %b exp 1010", bank_valid); end
    bank_ready = 4'b1010;
    n_checks++; if (bank_data !== 50'h0ABC_1234_5678) begin n_fail++; $display("FAIL part_data_stable got %h exp 0abc12345678", bank_data); end
    step;
    bank_ready = '0;
    n_checks++; if (bank_valid !== 4'h0) begin n_fail++; $display("FAIL part_after_pop got %b exp 0000", bank_valid); end
    n_checks++; if (cmd_count !== 32'd1) begin n_fail++; $display("FAIL part_cmd_count got %0d exp 1", cmd_count); end
  endtask

  task automatic test_full_and_release;
    int acc;
    do_reset;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_data = W'(100 + i); in_last = 0;
      if (in_ready) acc++;
      step;
    end
    n_checks++; if (acc != 2) begin n_fail++; $display("FAIL full_accepts got %0d exp 2", acc); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b exp 0", in_ready); end
    n_checks++; if (cmd_count !== 32'd0 || bank_data !== W'(100)) begin n_fail++; $display("FAIL full_state got cnt %0d data %0d exp 0/100", cmd_count, bank_data); end
    in_data = W'(200);
    bank_ready = '1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL release_same_cycle got %b exp 0", in_ready); end
    step;
    bank_ready = '0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_next_cycle got %b exp 1", in_ready); end
    n_checks++; if (cmd_count !== 32'd1 || bank_data !== W'(101)) begin n_fail++; $display("FAIL release_pop got cnt %0d data %0d exp 1/101", cmd_count, bank_data); end
    in_valid = 0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    in_valid = 1; in_data = W'(11); in_last = 0;
    step;
    in_data = W'(12);
    step;
    in_valid = 0;
    bank_ready = 4'b0011;
    step;
    bank_ready = '0;
    n_checks++; if (bank_valid !== 4'b1100) begin n_fail++; $display("FAIL mid_partial got %b exp 1100", bank_valid); end
    reset = 1;
    step;
    n_checks++; if (in_ready !== 1'b0 || bank_valid !== 4'h0 || bank_data !== '0 || bank_last !== 1'b0 || seed_valid !== 1'b0 || cmd_count !== 32'd0)
      begin n_fail++; $display("FAIL mid_reset_outputs got rdy %b bv %b data %h cnt %0d", in_ready, bank_valid, bank_data, cmd_count); end
    reset = 0;
    bank_ready = '1;
    step;
    n_checks++; if (bank_valid !== 4'h0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_after_reset got bv %b rdy %b exp 0000/1", bank_valid, in_ready); end
    step;
    n_checks++; if (bank_valid !== 4'h0 || cmd_count !== 32'd0) begin n_fail++; $display("FAIL mid_no_handshake got bv %b cnt %0d exp 0000/0", bank_valid, cmd_count); end
    bank_ready = '0;
    in_valid = 1; in_data = W'(300);
    step;
    in_valid = 0;
    n_checks++; if (bank_valid !== 4'hF || bank_data !== W'(300)) begin n_fail++; $display("FAIL mid_new_push got bv %b data %0d exp 1111/300", bank_valid, bank_data); end
  endtask

  task automatic test_after_last;
    do_reset;
    in_valid = 1; in_data = W'(32'h111); in_last = 1;
    step;
    in_data = W'(32'h222); in_last = 0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b exp 0", in_ready); end
    n_checks++; if (bank_data !== W'(32'h111) || bank_last !== 1'b1 || seed_valid !== 1'b0)
      begin n_fail++; $display("FAIL flush_head got %h/%b seed %b exp 111/1/0", bank_data, bank_last, seed_valid); end
    step; step;
    bank_ready = '1;
    n_checks++; if (bank_valid !== 4'hF || bank_data !== W'(32'h111)) begin n_fail++; $display("FAIL flush_extra_ignored got %b/%h exp 1111/111", bank_valid, bank_data); end
    step;
    n_checks++; if (seed_valid !== 1'b1 || in_ready !== 1'b0 || bank_valid !== 4'h0)
      begin n_fail++; $display("FAIL done_entry got seed %b rdy %b bv %b exp 1/0/0000", seed_valid, in_ready, bank_valid); end
    n_checks++; if (cmd_count !== 32'd1 || bank_data !== '0 || seed_intensity !== '0)
      begin n_fail++; $display("FAIL done_values got cnt %0d data %h int %h exp 1/0/0", cmd_count, bank_data, seed_intensity); end
    step; step; step;
    n_checks++; if (seed_valid !== 1'b1 || cmd_count !== 32'd1 || bank_valid !== 4'h0)
      begin n_fail++; $display("FAIL done_hold got seed %b cnt %0d bv %b exp 1/1/0000", seed_valid, cmd_count, bank_valid); end
    in_valid = 0;
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_partial_accept;
    test_full_and_release;
    test_reset_mid;
    test_after_last;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
